// File: rtl/pulp_cluster_package.sv
// Shared constants and payload types for the cluster peripheral interconnect.
package pulp_cluster_package;

  localparam int NB_SPERIPHS    = 11;
  localparam int PERIPH_SEL_LSB = 10;
  localparam int PERIPH_SEL_W   = 4;
  localparam int PERIPH_ADDR_W  = 32;
  localparam int PERIPH_DATA_W  = 32;

  localparam int SPER_EOC_ID         = 0;
  localparam int SPER_TIMER_ID       = 1;
  localparam int SPER_EVENT_U_ID     = 2;
  localparam int SPER_LOCKSTEP_ID    = 3;
  localparam int SPER_HWPE_ID        = 4;
  localparam int SPER_ICACHE_CTRL_ID = 5;
  localparam int SPER_DMA_CL_ID      = 6;
  localparam int SPER_DMA_FC_ID      = 7;
  localparam int SPER_DECOMP_ID      = 8;
  localparam int SPER_EXT_ID         = 9;
  localparam int SPER_RSVD_ID        = 10;

  typedef struct packed {
    logic [PERIPH_ADDR_W-1:0]   add;
    logic                       wen;
    logic [PERIPH_DATA_W-1:0]   wdata;
    logic [PERIPH_DATA_W/8-1:0] be;
  } periph_req_t;

  typedef struct packed {
    logic [PERIPH_DATA_W-1:0] rdata;
    logic                     opc;
  } periph_rsp_t;

  localparam periph_rsp_t ERR_RSP = '{rdata: 32'hBADACCE5, opc: 1'b1};

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cluster_periph_rr_arb.sv
// One round-robin arbiter for a single slave plug, with the pointer register
// and the pending-transaction slot that remembers which master to answer.
module cluster_periph_rr_arb
  import pulp_cluster_package::*;
#(
  parameter int NB_MASTERS = 9,
  parameter int IDX_W      = idx_w(NB_MASTERS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NB_MASTERS-1:0] req_i,
  input  logic                  gnt_i,
  input  logic                  r_valid_i,
  output logic                  req_o,
  output logic [IDX_W-1:0]      win_o,
  output logic                  rsp_vld_o,
  output logic [IDX_W-1:0]      rsp_id_o
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] pend_id_q, pend_id_d;
  logic             pend_vld_q, pend_vld_d;
  logic             found;
  logic             slot_free;
  logic             xfer;
  int               idx;

  // First requester at or after the pointer, wrapping at NB_MASTERS.
  always_comb begin
    found = 1'b0;
    win_o = '0;
    idx   = 0;
    for (int k = 0; k < NB_MASTERS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NB_MASTERS) idx = idx - NB_MASTERS;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win_o = IDX_W'(idx);
      end
    end
  end

  assign slot_free = !pend_vld_q || r_valid_i;
  assign req_o     = found && slot_free;
  assign xfer      = req_o && gnt_i;
  assign rsp_vld_o = pend_vld_q && r_valid_i;
  assign rsp_id_o  = pend_id_q;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    pend_id_d  = pend_id_q;
    pend_vld_d = pend_vld_q && !r_valid_i;
    if (xfer) begin
      pend_vld_d = 1'b1;
      pend_id_d  = win_o;
      rr_ptr_d   = (int'(win_o) == NB_MASTERS - 1) ? '0 : win_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      pend_id_q  <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      pend_id_q  <= pend_id_d;
      pend_vld_q <= pend_vld_d;
    end
  end

`ifndef SYNTHESIS
  // Sticky record of a slave answering with nothing outstanding; the response is dropped.
  logic proto_err_q, proto_err_d;

  always_comb begin
    proto_err_d = proto_err_q || (r_valid_i && !pend_vld_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) proto_err_q <= 1'b0;
    else         proto_err_q <= proto_err_d;
  end
`endif

endmodule

// File: rtl/cluster_periph_arb.sv
// Cluster peripheral request arbiter/router: address decode, per-slave round-robin,
// response routing. Define CLUSTER_PERIPH_ERR_SLAVE_EN to add an internal error slave.
module cluster_periph_arb
  import pulp_cluster_package::*;
#(
  parameter int NB_MASTERS = 9,
  parameter int NB_SLAVES  = NB_SPERIPHS,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NB_MASTERS-1:0]               m_req_i,
  output logic [NB_MASTERS-1:0]               m_gnt_o,
  input  logic [NB_MASTERS-1:0][ADDR_W-1:0]   m_add_i,
  input  logic [NB_MASTERS-1:0]               m_wen_i,
  input  logic [NB_MASTERS-1:0][DATA_W-1:0]   m_wdata_i,
  input  logic [NB_MASTERS-1:0][DATA_W/8-1:0] m_be_i,
  output logic [NB_MASTERS-1:0]               m_r_valid_o,
  output logic [NB_MASTERS-1:0][DATA_W-1:0]   m_r_rdata_o,
  output logic [NB_MASTERS-1:0]               m_r_opc_o,
  output logic [NB_SLAVES-1:0]                s_req_o,
  input  logic [NB_SLAVES-1:0]                s_gnt_i,
  output logic [NB_SLAVES-1:0][ADDR_W-1:0]    s_add_o,
  output logic [NB_SLAVES-1:0]                s_wen_o,
  output logic [NB_SLAVES-1:0][DATA_W-1:0]    s_wdata_o,
  output logic [NB_SLAVES-1:0][DATA_W/8-1:0]  s_be_o,
  input  logic [NB_SLAVES-1:0]                s_r_valid_i,
  input  logic [NB_SLAVES-1:0][DATA_W-1:0]    s_r_rdata_i,
  input  logic [NB_SLAVES-1:0]                s_r_opc_i
);

  localparam int IDX_W = idx_w(NB_MASTERS);

  logic [NB_MASTERS-1:0][PERIPH_SEL_W-1:0] sel;
  logic [NB_MASTERS-1:0][PERIPH_SEL_W-1:0] tgt;
  logic [NB_MASTERS-1:0]                   oor;
  logic [NB_MASTERS-1:0]                   tgt_req;
  logic [NB_SLAVES-1:0][NB_MASTERS-1:0]    cand;
  logic [NB_SLAVES-1:0][IDX_W-1:0]         win;
  logic [NB_SLAVES-1:0][IDX_W-1:0]         rsp_id;
  logic [NB_SLAVES-1:0]                    rsp_vld;

  // Out-of-range selects fall back to the EXT plug unless the error slave takes them.
  always_comb begin
    sel     = '0;
    tgt     = '0;
    oor     = '0;
    tgt_req = '0;
    cand    = '0;
    for (int m = 0; m < NB_MASTERS; m++) begin
      sel[m] = m_add_i[m][PERIPH_SEL_LSB +: PERIPH_SEL_W];
      oor[m] = int'(sel[m]) >= NB_SLAVES;
      tgt[m] = oor[m] ? PERIPH_SEL_W'(SPER_EXT_ID) : sel[m];
`ifdef CLUSTER_PERIPH_ERR_SLAVE_EN
      tgt_req[m] = m_req_i[m] && !oor[m];
`else
      tgt_req[m] = m_req_i[m];
`endif
      for (int s = 0; s < NB_SLAVES; s++) begin
        cand[s][m] = tgt_req[m] && (int'(tgt[m]) == s);
      end
    end
  end

  for (genvar s = 0; s < NB_SLAVES; s++) begin : g_slv
    cluster_periph_rr_arb #(
      .NB_MASTERS (NB_MASTERS),
      .IDX_W      (IDX_W)
    ) i_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (cand[s]),
      .gnt_i     (s_gnt_i[s]),
      .r_valid_i (s_r_valid_i[s]),
      .req_o     (s_req_o[s]),
      .win_o     (win[s]),
      .rsp_vld_o (rsp_vld[s]),
      .rsp_id_o  (rsp_id[s])
    );

    assign s_add_o[s]   = s_req_o[s] ? m_add_i[win[s]]   : '0;
    assign s_wen_o[s]   = s_req_o[s] ? m_wen_i[win[s]]   : 1'b0;
    assign s_wdata_o[s] = s_req_o[s] ? m_wdata_i[win[s]] : '0;
    assign s_be_o[s]    = s_req_o[s] ? m_be_i[win[s]]    : '0;
  end

`ifdef CLUSTER_PERIPH_ERR_SLAVE_EN
  logic [NB_MASTERS-1:0] err_req;
  logic                  err_req_vld;
  logic [IDX_W-1:0]      err_win;
  logic                  err_rsp_vld;
  logic [IDX_W-1:0]      err_rsp_id;
  logic                  err_rvld_q, err_rvld_d;

  assign err_req = m_req_i & oor;

  cluster_periph_rr_arb #(
    .NB_MASTERS (NB_MASTERS),
    .IDX_W      (IDX_W)
  ) i_err_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (err_req),
    .gnt_i     (1'b1),
    .r_valid_i (err_rvld_q),
    .req_o     (err_req_vld),
    .win_o     (err_win),
    .rsp_vld_o (err_rsp_vld),
    .rsp_id_o  (err_rsp_id)
  );

  // The error slave always grants and answers exactly one cycle later.
  always_comb begin
    err_rvld_d = err_req_vld;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_rvld_q <= 1'b0;
    else         err_rvld_q <= err_rvld_d;
  end
`endif

  always_comb begin
    m_gnt_o     = '0;
    m_r_valid_o = '0;
    m_r_rdata_o = '0;
    m_r_opc_o   = '0;
    for (int s = 0; s < NB_SLAVES; s++) begin
      if (s_req_o[s] && s_gnt_i[s]) m_gnt_o[win[s]] = 1'b1;
      if (rsp_vld[s]) begin
        m_r_valid_o[rsp_id[s]] = 1'b1;
        m_r_rdata_o[rsp_id[s]] = s_r_rdata_i[s];
        m_r_opc_o[rsp_id[s]]   = s_r_opc_i[s];
      end
    end
`ifdef CLUSTER_PERIPH_ERR_SLAVE_EN
    if (err_req_vld) m_gnt_o[err_win] = 1'b1;
    if (err_rsp_vld) begin
      m_r_valid_o[err_rsp_id] = 1'b1;
      m_r_rdata_o[err_rsp_id] = DATA_W'(ERR_RSP.rdata);
      m_r_opc_o[err_rsp_id]   = ERR_RSP.opc;
    end
`endif
  end

endmodule
